// File: rtl/security_xf_arbiter.sv
// security_xf_arbiter
//   Shares one combinational security transform between two requesters.
//   The memory path uses the encrypt direction (key_access_mem) and the
//   register path uses the decrypt direction (key_access_reg). The block
//   checks the requester's key, presents the operand and key to the
//   transform for XF_LAT cycles, and then captures the result. The result
//   goes back over a valid/ready response channel for that requester. A
//   requester that fails the key check MAX_FAIL times in a row is locked
//   out for LOCK_CYCLES cycles.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   mem_req_*_i / _o       memory-path request (valid, ready, data, key)
//   mem_rsp_*_i / _o       memory-path response (valid, ready, data, err)
//   mem_locked_o           memory path currently locked out
//   reg_req_* / reg_rsp_*  same set of ports for the register path
//   reg_locked_o           register path currently locked out
//   xf_data_in_o           operand driven to the transform
//   xf_key_mem_o           transform key_access_mem
//   xf_key_reg_o           transform key_access_reg
//   xf_data_out_i          transform result
module security_xf_arbiter #(
  parameter logic [15:0] KEY         = 16'h0032,
  parameter int          XF_LAT      = 2,
  parameter int          MAX_FAIL    = 3,
  parameter int          LOCK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_valid_i,
  output logic        mem_req_ready_o,
  input  logic [31:0] mem_req_data_i,
  input  logic [15:0] mem_req_key_i,
  output logic        mem_rsp_valid_o,
  input  logic        mem_rsp_ready_i,
  output logic [31:0] mem_rsp_data_o,
  output logic        mem_rsp_err_o,
  output logic        mem_locked_o,
  input  logic        reg_req_valid_i,
  output logic        reg_req_ready_o,
  input  logic [31:0] reg_req_data_i,
  input  logic [15:0] reg_req_key_i,
  output logic        reg_rsp_valid_o,
  input  logic        reg_rsp_ready_i,
  output logic [31:0] reg_rsp_data_o,
  output logic        reg_rsp_err_o,
  output logic        reg_locked_o,
  output logic [31:0] xf_data_in_o,
  output logic [15:0] xf_key_mem_o,
  output logic [15:0] xf_key_reg_o,
  input  logic [31:0] xf_data_out_i
);

  localparam int LW = $clog2(XF_LAT + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int KW = $clog2(LOCK_CYCLES + 1);

  // Side index 0 is the memory path, index 1 is the register path.
  localparam logic SIDE_MEM = 1'b0;
  localparam logic SIDE_REG = 1'b1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                 state_q;
  logic [LW-1:0]          lat_q;
  logic                   grant_q;
  logic                   last_grant_q;
  logic [31:0]            xf_data_q;
  logic [15:0]            xf_key_mem_q;
  logic [15:0]            xf_key_reg_q;
  logic [1:0]             rsp_valid_q;
  logic [1:0][31:0]       rsp_data_q;
  logic [1:0]             rsp_err_q;
  logic [1:0][FW-1:0]     fail_q, fail_d;
  logic [1:0][KW-1:0]     lock_q, lock_d;

  logic [1:0]             req_valid, rsp_ready, locked, eligible, ready;
  logic [1:0]             bad_key, done;
  logic [1:0][31:0]       req_data;
  logic [1:0][15:0]       req_key;
  logic                   idle, acc_any, acc_side, acc_key_ok;

  assign req_valid = {reg_req_valid_i, mem_req_valid_i};
  assign rsp_ready = {reg_rsp_ready_i, mem_rsp_ready_i};
  assign req_data  = {reg_req_data_i, mem_req_data_i};
  assign req_key   = {reg_req_key_i, mem_req_key_i};
  assign locked    = {lock_q[1] != '0, lock_q[0] != '0};
  assign eligible  = req_valid & ~locked;

  // Ready is combinational, so it is also gated by rst. Otherwise a held
  // req_valid would show ready while reset is asserted.
  assign idle     = (state_q == IDLE) && !rst;
  assign ready[0] = idle && eligible[0] && (!eligible[1] || last_grant_q == SIDE_REG);
  assign ready[1] = idle && eligible[1] && (!eligible[0] || last_grant_q == SIDE_MEM);

  assign acc_any    = |ready;
  assign acc_side   = ready[1];
  assign acc_key_ok = (req_key[acc_side] == KEY);

  assign bad_key[0] = ready[0] && (req_key[0] != KEY);
  assign bad_key[1] = ready[1] && (req_key[1] != KEY);
  assign done[0]    = (state_q == BUSY) && (lat_q == LW'(1)) && (grant_q == SIDE_MEM);
  assign done[1]    = (state_q == BUSY) && (lat_q == LW'(1)) && (grant_q == SIDE_REG);

  // Per-side failure and lockout bookkeeping. The lock counter runs in
  // every state. Reaching MAX_FAIL reloads the lock counter, and that
  // reload takes priority over the countdown.
  always_comb begin
    fail_d = fail_q;
    lock_d = lock_q;
    for (int s = 0; s < 2; s++) begin
      if (lock_q[s] != '0) begin
        lock_d[s] = lock_q[s] - KW'(1);
      end
      if (bad_key[s]) begin
        if (fail_q[s] == FW'(MAX_FAIL - 1)) begin
          fail_d[s] = '0;
          lock_d[s] = KW'(LOCK_CYCLES);
        end else begin
          fail_d[s] = fail_q[s] + FW'(1);
        end
      end else if (done[s]) begin
        fail_d[s] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_q <= '0;
      lock_q <= '0;
    end else begin
      fail_q <= fail_d;
      lock_q <= lock_d;
    end
  end

  // Transaction FSM. The transform inputs are loaded only for a good key
  // and are cleared on the capture edge. As a result, outside BUSY the
  // transform sees zero operands and neither key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      grant_q      <= SIDE_MEM;
      last_grant_q <= SIDE_REG;
      xf_data_q    <= '0;
      xf_key_mem_q <= '0;
      xf_key_reg_q <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc_any) begin
            grant_q      <= acc_side;
            last_grant_q <= acc_side;
            if (acc_key_ok) begin
              xf_data_q    <= req_data[acc_side];
              xf_key_mem_q <= (acc_side == SIDE_MEM) ? KEY : 16'h0000;
              xf_key_reg_q <= (acc_side == SIDE_REG) ? KEY : 16'h0000;
              lat_q        <= LW'(XF_LAT);
              state_q      <= BUSY;
            end else begin
              rsp_valid_q[acc_side] <= 1'b1;
              rsp_data_q[acc_side]  <= '0;
              rsp_err_q[acc_side]   <= 1'b1;
              state_q               <= RESP;
            end
          end
        end
        BUSY: begin
          if (lat_q == LW'(1)) begin
            rsp_valid_q[grant_q] <= 1'b1;
            rsp_data_q[grant_q]  <= xf_data_out_i;
            rsp_err_q[grant_q]   <= 1'b0;
            xf_data_q            <= '0;
            xf_key_mem_q         <= '0;
            xf_key_reg_q         <= '0;
            state_q              <= RESP;
          end else begin
            lat_q <= lat_q - LW'(1);
          end
        end
        RESP: begin
          if (rsp_ready[grant_q]) begin
            rsp_valid_q[grant_q] <= 1'b0;
            rsp_data_q[grant_q]  <= '0;
            rsp_err_q[grant_q]   <= 1'b0;
            state_q              <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_ready_o = ready[0];
  assign reg_req_ready_o = ready[1];
  assign mem_rsp_valid_o = rsp_valid_q[0];
  assign reg_rsp_valid_o = rsp_valid_q[1];
  assign mem_rsp_data_o  = rsp_data_q[0];
  assign reg_rsp_data_o  = rsp_data_q[1];
  assign mem_rsp_err_o   = rsp_err_q[0];
  assign reg_rsp_err_o   = rsp_err_q[1];
  assign mem_locked_o    = locked[0];
  assign reg_locked_o    = locked[1];
  assign xf_data_in_o    = xf_data_q;
  assign xf_key_mem_o    = xf_key_mem_q;
  assign xf_key_reg_o    = xf_key_reg_q;

endmodule

// File: tb/tb_security_xf_arbiter.sv
// tb_security_xf_arbiter
//   Directed bench for security_xf_arbiter. A small combinational transform
//   model stands in for the real transform:
//     encrypt (key_access_mem valid): ((d - 3) ^ 2 + 9) * 3
//     decrypt (key_access_reg valid): d / 3 - 11   (30 -> 32'hFFFFFFFF)
//     neither key, or both keys:      0
module tb_security_xf_arbiter;

  localparam logic [15:0] KEY = 16'h0032;
  localparam logic [15:0] BAD = 16'h1234;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memReqValid = 1'b0, memReqReady;
  logic [31:0] memReqData = '0;
  logic [15:0] memReqKey = '0;
  logic        memRspValid, memRspReady = 1'b0, memRspErr, memLocked;
  logic [31:0] memRspData;
  logic        regReqValid = 1'b0, regReqReady;
  logic [31:0] regReqData = '0;
  logic [15:0] regReqKey = '0;
  logic        regRspValid, regRspReady = 1'b0, regRspErr, regLocked;
  logic [31:0] regRspData;
  logic [31:0] xfDataIn, xfDataOut;
  logic [15:0] xfKeyMem, xfKeyReg;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] xfModel(input logic [31:0] d, input logic [15:0] km,
                                          input logic [15:0] kr);
    if (km == KEY && kr == 16'h0) return (((d - 32'd3) ^ 32'd2) + 32'd9) * 32'd3;
    if (kr == KEY && km == 16'h0) return (d / 32'd3) - 32'd11;
    return 32'h0;
  endfunction

  assign xfDataOut = xfModel(xfDataIn, xfKeyMem, xfKeyReg);

  security_xf_arbiter dut (
    .clk(clk), .rst(rst),
    .mem_req_valid_i(memReqValid), .mem_req_ready_o(memReqReady),
    .mem_req_data_i(memReqData), .mem_req_key_i(memReqKey),
    .mem_rsp_valid_o(memRspValid), .mem_rsp_ready_i(memRspReady),
    .mem_rsp_data_o(memRspData), .mem_rsp_err_o(memRspErr), .mem_locked_o(memLocked),
    .reg_req_valid_i(regReqValid), .reg_req_ready_o(regReqReady),
    .reg_req_data_i(regReqData), .reg_req_key_i(regReqKey),
    .reg_rsp_valid_o(regRspValid), .reg_rsp_ready_i(regRspReady),
    .reg_rsp_data_o(regRspData), .reg_rsp_err_o(regRspErr), .reg_locked_o(regLocked),
    .xf_data_in_o(xfDataIn), .xf_key_mem_o(xfKeyMem), .xf_key_reg_o(xfKeyReg),
    .xf_data_out_i(xfDataOut)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // The transform must never see both keys valid at the same time.
  always @(negedge clk) begin
    if (!rst) checkOutput("xfKeysExclusive", 32'(xfKeyMem != 16'h0 && xfKeyReg != 16'h0), 32'h0);
  end

  // Issues one request on a side, checks the transform inputs during BUSY,
  // checks the accept-to-valid latency, the response data and err, and then
  // completes the handshake.
  task automatic applyStimulus(input bit side, input logic [31:0] data, input logic [15:0] key,
                               input int expLat, input logic [31:0] expData,
                               input logic expErr, input string tag);
    int n;
    if (side) begin
      regReqValid = 1'b1; regReqData = data; regReqKey = key; regRspReady = 1'b0;
    end else begin
      memReqValid = 1'b1; memReqData = data; memReqKey = key; memRspReady = 1'b0;
    end
    #1;
    n = 0;
    while (!(side ? regReqReady : memReqReady) && n < 50) begin
      tick();
      n++;
    end
    checkOutput($sformatf("%s_ready", tag), 32'(side ? regReqReady : memReqReady), 32'h1);
    tick();
    if (side) regReqValid = 1'b0; else memReqValid = 1'b0;
    n = 1;
    while (!(side ? regRspValid : memRspValid) && n < 50) begin
      if (!expErr) begin
        checkOutput($sformatf("%s_xfKeyOwn", tag), 32'(side ? xfKeyReg : xfKeyMem), 32'(KEY));
        checkOutput($sformatf("%s_xfKeyOther", tag), 32'(side ? xfKeyMem : xfKeyReg), 32'h0);
        checkOutput($sformatf("%s_xfDataIn", tag), xfDataIn, data);
      end
      tick();
      n++;
    end
    checkOutput($sformatf("%s_latency", tag), 32'(n), 32'(expLat));
    checkOutput($sformatf("%s_data", tag), side ? regRspData : memRspData, expData);
    checkOutput($sformatf("%s_err", tag), 32'(side ? regRspErr : memRspErr), 32'(expErr));
    if (side) regRspReady = 1'b1; else memRspReady = 1'b1;
    tick();
    if (side) regRspReady = 1'b0; else memRspReady = 1'b0;
    checkOutput($sformatf("%s_validDrop", tag), 32'(side ? regRspValid : memRspValid), 32'h0);
  endtask

  initial begin
    int n, lockSamples, regServed;
    bit sawReady, expSide, gotSide;

    // Reset state; a held request must not see ready during reset.
    memReqValid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_memReqReady", 32'(memReqReady), 32'h0);
    checkOutput("rst_memRspValid", 32'(memRspValid), 32'h0);
    checkOutput("rst_regRspValid", 32'(regRspValid), 32'h0);
    checkOutput("rst_xfDataIn", xfDataIn, 32'h0);
    checkOutput("rst_xfKeyMem", 32'(xfKeyMem), 32'h0);
    checkOutput("rst_xfKeyReg", 32'(xfKeyReg), 32'h0);
    checkOutput("rst_memLocked", 32'(memLocked), 32'h0);
    memReqValid = 1'b0;
    rst = 1'b0;
    tick();

    // Encrypt and decrypt paths.
    applyStimulus(1'b0, 32'd10, KEY, 3, 32'd42, 1'b0, "enc");
    applyStimulus(1'b1, 32'd30, KEY, 3, 32'hFFFFFFFF, 1'b0, "dec");

    // Round-robin from reset: MEM, REG, MEM, REG.
    doReset();
    memReqValid = 1'b1; memReqData = 32'd10; memReqKey = KEY;
    regReqValid = 1'b1; regReqData = 32'd30; regReqKey = KEY;
    for (int g = 0; g < 4; g++) begin
      expSide = (g % 2) == 1;
      #1;
      n = 0;
      while (!(memReqReady || regReqReady) && n < 50) begin
        tick();
        n++;
      end
      checkOutput($sformatf("arb%0d_regReady", g), 32'(regReqReady), 32'(expSide));
      checkOutput($sformatf("arb%0d_memReady", g), 32'(memReqReady), 32'(!expSide));
      gotSide = regReqReady;
      tick();
      if (gotSide) regReqValid = 1'b0; else memReqValid = 1'b0;
      n = 0;
      while (!(gotSide ? regRspValid : memRspValid) && n < 50) begin
        tick();
        n++;
      end
      checkOutput($sformatf("arb%0d_data", g), gotSide ? regRspData : memRspData,
                  gotSide ? 32'hFFFFFFFF : 32'd42);
      if (gotSide) regRspReady = 1'b1; else memRspReady = 1'b1;
      tick();
      regRspReady = 1'b0; memRspReady = 1'b0;
      if (g < 3) begin
        if (gotSide) regReqValid = 1'b1; else memReqValid = 1'b1;
      end
    end
    memReqValid = 1'b0; regReqValid = 1'b0;
    tick();

    // Response back-pressure: the response stays stable and REG stalls.
    memReqValid = 1'b1; memReqData = 32'd10; memReqKey = KEY;
    #1;
    checkOutput("stall_memReady", 32'(memReqReady), 32'h1);
    tick();
    memReqValid = 1'b0;
    n = 1;
    while (!memRspValid && n < 50) begin
      tick();
      n++;
    end
    regReqValid = 1'b1; regReqData = 32'd30; regReqKey = KEY;
    #1;
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("stall%0d_valid", c), 32'(memRspValid), 32'h1);
      checkOutput($sformatf("stall%0d_data", c), memRspData, 32'd42);
      checkOutput($sformatf("stall%0d_err", c), 32'(memRspErr), 32'h0);
      checkOutput($sformatf("stall%0d_regReady", c), 32'(regReqReady), 32'h0);
      tick();
    end
    memRspReady = 1'b1;
    #1;
    checkOutput("stall_regReadyAtHs", 32'(regReqReady), 32'h0);
    tick();
    memRspReady = 1'b0;
    checkOutput("stall_memValidDrop", 32'(memRspValid), 32'h0);
    checkOutput("stall_regReadyAfter", 32'(regReqReady), 32'h1);
    applyStimulus(1'b1, 32'd30, KEY, 3, 32'hFFFFFFFF, 1'b0, "stallReg");

    // Lockout after three bad keys on MEM; REG keeps being served.
    doReset();
    applyStimulus(1'b0, 32'd5, BAD, 1, 32'h0, 1'b1, "bad1");
    checkOutput("bad1_locked", 32'(memLocked), 32'h0);
    applyStimulus(1'b0, 32'd5, BAD, 1, 32'h0, 1'b1, "bad2");
    checkOutput("bad2_locked", 32'(memLocked), 32'h0);
    memReqValid = 1'b1; memReqData = 32'd5; memReqKey = BAD;
    #1;
    checkOutput("bad3_ready", 32'(memReqReady), 32'h1);
    tick();
    memReqData = 32'd10; memReqKey = KEY;
    checkOutput("bad3_valid", 32'(memRspValid), 32'h1);
    checkOutput("bad3_err", 32'(memRspErr), 32'h1);
    checkOutput("bad3_data", memRspData, 32'h0);
    checkOutput("bad3_locked", 32'(memLocked), 32'h1);
    memRspReady = 1'b1;
    regReqValid = 1'b1; regReqData = 32'd30; regReqKey = KEY; regRspReady = 1'b1;
    lockSamples = 1; regServed = 0; sawReady = 1'b0; n = 0;
    while (memLocked && n < 100) begin
      tick();
      n++;
      if (memLocked) begin
        lockSamples++;
        if (memReqReady) sawReady = 1'b1;
      end
      if (regRspValid) regServed++;
    end
    regReqValid = 1'b0;
    checkOutput("lock_cycles", 32'(lockSamples), 32'd16);
    checkOutput("lock_noMemReady", 32'(sawReady), 32'h0);
    checkOutput("lock_regServed", 32'(regServed != 0), 32'h1);
    applyStimulus(1'b0, 32'd10, KEY, 3, 32'd42, 1'b0, "unlocked");
    regRspReady = 1'b0;

    // Reset in the middle of BUSY; the fail count is cleared too.
    applyStimulus(1'b0, 32'd5, BAD, 1, 32'h0, 1'b1, "preRstBad1");
    applyStimulus(1'b0, 32'd5, BAD, 1, 32'h0, 1'b1, "preRstBad2");
    memReqValid = 1'b1; memReqData = 32'd10; memReqKey = KEY;
    #1;
    tick();
    checkOutput("busy_xfKeyMem", 32'(xfKeyMem), 32'(KEY));
    rst = 1'b1;
    #1;
    checkOutput("midRst_xfKeyMem", 32'(xfKeyMem), 32'h0);
    checkOutput("midRst_xfDataIn", xfDataIn, 32'h0);
    checkOutput("midRst_memRspValid", 32'(memRspValid), 32'h0);
    checkOutput("midRst_memReqReady", 32'(memReqReady), 32'h0);
    memReqValid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checkOutput("postRst_noStale", 32'(memRspValid), 32'h0);
    applyStimulus(1'b0, 32'd5, BAD, 1, 32'h0, 1'b1, "postRstBad");
    checkOutput("postRst_notLocked", 32'(memLocked), 32'h0);
    applyStimulus(1'b0, 32'd10, KEY, 3, 32'd42, 1'b0, "postRst");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/security_xf_arbiter.md
Name: security_xf_arbiter

Overview:
- Shares one security transform unit between two requesters: the memory path (encrypt direction, driven via key_access_mem) and the register path (decrypt direction, driven via key_access_reg).
- Checks the requester-supplied key, drives the transform's key inputs and data, and waits a fixed settle latency before capturing the result.
- Returns the result over a per-requester valid/ready response channel.
- Locks out a requester that fails the key check repeatedly.
- Sits between the bus-side requesters and the combinational transform instance.

Parameters:
- KEY, 16'h0032, access key the transform recognises; the only key that passes the check.
- XF_LAT, 2, cycles the transform inputs are held before result capture; must be at least 1.
- MAX_FAIL, 3, consecutive key failures that trigger lockout.
- LOCK_CYCLES, 16, lockout duration in clock cycles.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req_valid  in  1  memory-path request valid.
- mem_req_ready  out  1  memory-path request accepted this cycle.
- mem_req_data  in  32  memory-path operand.
- mem_req_key  in  16  memory-path key.
- mem_rsp_valid  out  1  memory-path response valid.
- mem_rsp_ready  in  1  memory-path response consumed.
- mem_rsp_data  out  32  memory-path result.
- mem_rsp_err  out  1  key rejected; data is 0.
- mem_locked  out  1  memory path in lockout.
- reg_req_valid, reg_req_ready, reg_req_data, reg_req_key, reg_rsp_valid, reg_rsp_ready, reg_rsp_data, reg_rsp_err, reg_locked: identical to the memory-path ports, for the register path.
- xf_data_in  out  32  operand to the transform.
- xf_key_mem  out  16  transform key_access_mem.
- xf_key_reg  out  16  transform key_access_reg.
- xf_data_out  in  32  transform result.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = REG, so MEM wins the first tie; fail and lock counters 0.
- States: IDLE, BUSY, RESP.
- IDLE:
  - Eligible requester: req_valid=1 and locked=0.
  - mem_req_ready = IDLE and mem eligible and (reg not eligible or last_grant==REG). reg_req_ready is symmetric.
  - Round-robin: on a tie, the requester not granted last wins; at most one ready is high per cycle.
  - On accept: latch data, key and grant; update last_grant.
  - If latched key == KEY: go BUSY, load counter with XF_LAT.
  - Else: go RESP with err=1 and data=0; increment that requester's fail count.
- BUSY:
  - xf_data_in = latched data.
  - Granted side's xf key = KEY; the other xf key = 0.
  - Held for exactly XF_LAT cycles.
  - On the edge ending the last BUSY cycle, capture xf_data_out into the granted side's rsp_data and go RESP.
  - Successful completion clears that requester's fail count.
  - Outside BUSY, xf_data_in and both xf keys are 0, so the transform never sees both keys valid.
- RESP:
  - Granted side's rsp_valid=1; data and err held stable until rsp_ready=1.
  - On that edge, rsp_valid drops and the state returns to IDLE.
  - No new request is accepted until the edge after the handshake completes.
- Latency from accept edge to rsp_valid:
  - Good key: XF_LAT+1 edges.
  - Bad key: 1 edge.
- Lockout:
  - When a fail count reaches MAX_FAIL: load that side's lock counter with LOCK_CYCLES, clear the fail count, assert locked.
  - The lock counter decrements every cycle in any state; locked deasserts on the edge where the counter reaches 0.
  - A locked side never receives ready. Its pending response, if any, still completes.
- Simultaneous events:
  - A request arriving during BUSY/RESP waits; req_valid must stay high until ready.
  - The other side's lock counter keeps running during a transaction.
- Reset asserted mid-transaction:
  - Immediate return to IDLE; all outputs 0; in-flight result discarded.
  - Fail and lock counters cleared.

Test Plan:
- Encrypt path, XF_LAT=2: mem_req data=10, key=16'h0032; bench transform model returns 42 (((10-3)^2+9)*3) -> xf_key_mem=0x0032 and xf_key_reg=0 for 2 cycles; mem_rsp_valid 3 edges after accept; data=42, err=0.
- Decrypt path: reg_req data=30, key=0x0032 -> xf_key_reg=0x0032; reg_rsp_data=32'hFFFFFFFF; xf_key_mem=0 throughout.
- Both valid in the same cycle from reset -> MEM granted first, REG next; repeat with both valid -> grants alternate MEM, REG, MEM, REG.
- mem key 0x1234 three times -> each response err=1, data=0, 1-edge latency; after the third, mem_locked=1 for 16 cycles; reg requests still serviced meanwhile; mem accepted again once unlocked.
- Hold mem_rsp_ready=0 for 5 cycles -> rsp_valid, data and err stable; reg request stalls with ready=0 until the handshake completes.
- Assert rst during BUSY -> all outputs 0 immediately; the next mem request completes normally.
